// File: rtl/fpu_mem_responder_if.sv
// Request/response bundle between FPU job-manager initiators and the memory responder.
// Every field is flattened across NPORTS initiator ports.
interface fpu_mem_responder_if #(
   parameter int NPORTS = 4,
   parameter int PTR_W  = 23,
   parameter int DATA_W = 32
);
   logic [NPORTS-1:0]        req_avail;
   logic [NPORTS-1:0]        req_r_en;
   logic [NPORTS-1:0]        req_w_en;
   logic [NPORTS*PTR_W-1:0]  req_ptr;
   logic [NPORTS*DATA_W-1:0] req_data_store;
   logic [NPORTS*DATA_W-1:0] resp_data_load;
   logic [NPORTS-1:0]        resp_done;

   modport master (
      output req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
      input  resp_data_load, resp_done
   );

   modport slave (
      input  req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
      output resp_data_load, resp_done
   );
endinterface

// File: rtl/fpu_mem_responder.sv
// Single-ported word array serving NPORTS mem_handle initiators with round-robin
// arbitration, plus a host port that has priority for preload and inspection.
module fpu_mem_responder #(
   parameter int NPORTS = 4,
   parameter int DEPTH  = 256,
   parameter int PTR_W  = 23,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_l,
   fpu_mem_responder_if.slave       mem,
   input  logic                     host_we,
   input  logic                     host_re,
   input  logic [$clog2(DEPTH)-1:0] host_addr,
   input  logic [DATA_W-1:0]        host_wdata,
   output logic [DATA_W-1:0]        host_rdata,
   output logic                     err
);

   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

   typedef enum logic {ST_IDLE, ST_DONE} port_st_e;

   port_st_e                  st_q [NPORTS];
   logic [DATA_W-1:0]         mem_q [DEPTH];
   logic [IDX_W-1:0]          rr_next_q;
   logic [NPORTS-1:0]         done_q;
   logic [NPORTS*DATA_W-1:0]  load_q;

   logic                      host_busy;
   logic [NPORTS-1:0]         pending;
   logic                      gnt_vld;
   logic [IDX_W-1:0]          gnt_idx;
   int                        cand;
   logic [PTR_W-1:0]          gnt_ptr;
   logic [DATA_W-1:0]         gnt_wdata;
   logic                      gnt_r_en;
   logic                      gnt_w_en;
   logic                      gnt_in_range;
   logic [AW-1:0]             gnt_addr;
   logic [DATA_W-1:0]         gnt_rd_word;

   function automatic logic [IDX_W-1:0] rr_succ(input logic [IDX_W-1:0] idx);
      if (int'(idx) == NPORTS-1) return '0;
      return idx + IDX_W'(1);
   endfunction

   assign host_busy = host_we | host_re;

   // A port in DONE is not pending, so a long-held avail never re-executes or steals slots.
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         pending[i] = mem.req_avail[i] && (st_q[i] == ST_IDLE) && !host_busy && rst_l;
      end
   end

   // Walk downward so the candidate closest to rr_next_q is the one left standing.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int k = NPORTS-1; k >= 0; k--) begin
         cand = (int'(rr_next_q) + k) % NPORTS;
         if (pending[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(cand);
         end
      end
   end

   assign gnt_ptr      = mem.req_ptr[int'(gnt_idx)*PTR_W +: PTR_W];
   assign gnt_wdata    = mem.req_data_store[int'(gnt_idx)*DATA_W +: DATA_W];
   assign gnt_r_en     = mem.req_r_en[gnt_idx];
   assign gnt_w_en     = mem.req_w_en[gnt_idx];
   assign gnt_in_range = ({1'b0, gnt_ptr} < DEPTH_P);
   assign gnt_addr     = gnt_ptr[AW-1:0];
   assign gnt_rd_word  = mem_q[gnt_addr];

   // Array contents survive reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         if (host_we) begin
            mem_q[host_addr] <= host_wdata;
         end else if (gnt_vld && gnt_w_en && gnt_in_range) begin
            mem_q[gnt_addr] <= gnt_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < NPORTS; i++) begin
            st_q[i] <= ST_IDLE;
         end
         done_q     <= '0;
         load_q     <= '0;
         rr_next_q  <= '0;
         err        <= 1'b0;
         host_rdata <= '0;
      end else begin
         if (host_re) begin
            host_rdata <= mem_q[host_addr];
         end
         for (int i = 0; i < NPORTS; i++) begin
            case (st_q[i])
               ST_IDLE: begin
                  if (gnt_vld && (int'(gnt_idx) == i)) begin
                     st_q[i]   <= ST_DONE;
                     done_q[i] <= 1'b1;
                     if (!gnt_in_range) begin
                        load_q[i*DATA_W +: DATA_W] <= '0;
                     end else if (gnt_r_en) begin
                        load_q[i*DATA_W +: DATA_W] <= gnt_rd_word;
                     end
                  end
               end
               ST_DONE: begin
                  if (!mem.req_avail[i]) begin
                     st_q[i]   <= ST_IDLE;
                     done_q[i] <= 1'b0;
                  end
               end
               default: begin
                  st_q[i]   <= ST_IDLE;
                  done_q[i] <= 1'b0;
               end
            endcase
         end
         if (gnt_vld) begin
            rr_next_q <= rr_succ(gnt_idx);
            if (!gnt_in_range) begin
               err <= 1'b1;
            end
         end
      end
   end

   assign mem.resp_done      = done_q;
   assign mem.resp_data_load = load_q;

endmodule

// File: tb/tb_fpu_mem_responder.sv
// Directed bench for fpu_mem_responder: preload, handshake, arbitration order,
// host priority, range errors and reset behaviour.
module tb_fpu_mem_responder;
   localparam int NP = 4;
   localparam int DEPTH = 256;
   localparam int PW = 23;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_l;
   always #5 clk = ~clk;

   fpu_mem_responder_if #(.NPORTS(NP), .PTR_W(PW), .DATA_W(DW)) mif ();

   logic          host_we, host_re;
   logic [7:0]    host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          err;

   logic [NP-1:0] avail, r_en, w_en;
   logic [PW-1:0] ptr [NP];
   logic [DW-1:0] wd  [NP];

   assign mif.req_avail = avail;
   assign mif.req_r_en  = r_en;
   assign mif.req_w_en  = w_en;
   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign mif.req_ptr[g*PW +: PW]        = ptr[g];
      assign mif.req_data_store[g*DW +: DW] = wd[g];
   end

   fpu_mem_responder #(.NPORTS(NP), .DEPTH(DEPTH), .PTR_W(PW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .mem        (mif.slave),
      .host_we    (host_we),
      .host_re    (host_re),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .err        (err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] load(input int i);
      return mif.resp_data_load[i*DW +: DW];
   endfunction

   task automatic host_wr(input int a, input logic [DW-1:0] d);
      host_we = 1'b1; host_addr = 8'(a); host_wdata = d;
      step();
      host_we = 1'b0;
   endtask

   task automatic host_rd(input string tag, input int a, input logic [DW-1:0] exp);
      host_re = 1'b1; host_addr = 8'(a);
      step();
      host_re = 1'b0;
      check(tag, host_rdata, exp);
   endtask

   task automatic port_set(input int i, input logic av, input logic re, input logic we,
                           input int p, input logic [DW-1:0] d);
      avail[i] = av; r_en[i] = re; w_en[i] = we; ptr[i] = PW'(p); wd[i] = d;
   endtask

   initial begin
      host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;
      avail = '0; r_en = '0; w_en = '0;
      for (int i = 0; i < NP; i++) begin ptr[i] = '0; wd[i] = '0; end
      rst_l = 1'b1;
      #2 rst_l = 1'b0;
      step(); step();
      check("rst_done",  mif.resp_done, 0);
      check("rst_load",  mif.resp_data_load, 0);
      check("rst_rdata", host_rdata, 0);
      check("rst_err",   err, 0);
      rst_l = 1'b1;

      // Preload and a single read on port 1
      host_wr(0, 1); host_wr(1, 3); host_wr(2, 3); host_wr(3, 4); host_wr(4, 5);
      port_set(1, 1, 1, 0, 3, 0);
      check("p1_pre_done", mif.resp_done[1], 0);
      step();
      check("p1_done", mif.resp_done[1], 1);
      check("p1_load", load(1), 4);
      step();
      check("p1_hold_done", mif.resp_done[1], 1);
      check("p1_hold_load", load(1), 4);
      avail[1] = 1'b0;
      step();
      check("p1_done_fall", mif.resp_done[1], 0);

      // Port 3 write held 5 cycles; store data changes after the first cycle
      port_set(3, 1, 0, 1, 6, 32'h42);
      step();
      check("p3_done_c0", mif.resp_done[3], 1);
      wd[3] = 32'h99;
      for (int c = 1; c < 5; c++) begin
         step();
         check("p3_done_held", mif.resp_done[3], 1);
      end
      avail[3] = 1'b0;
      step();
      check("p3_done_fall", mif.resp_done[3], 0);
      host_rd("host_rd6", 6, 32'h42);

      // Read-before-write on port 1, then the new value is visible to port 2
      port_set(1, 1, 1, 1, 2, 7);
      step();
      check("rbw_old", load(1), 3);
      avail[1] = 1'b0; w_en[1] = 1'b0;
      step();
      port_set(2, 1, 1, 0, 2, 0);
      step();
      check("rbw_new", load(2), 7);
      avail[2] = 1'b0;
      step();

      // Round-robin from reset: all four ports at once
      rst_l = 1'b0;
      step();
      rst_l = 1'b1;
      port_set(0, 1, 1, 0, 0, 0);
      port_set(1, 1, 1, 0, 1, 0);
      port_set(2, 1, 1, 0, 3, 0);
      port_set(3, 1, 1, 0, 4, 0);
      step();
      check("rr_g0", mif.resp_done, 4'b0001);
      check("rr_l0", load(0), 1);
      avail[0] = 1'b0;
      step();
      check("rr_g1", mif.resp_done, 4'b0010);
      check("rr_l1", load(1), 3);
      port_set(0, 1, 1, 0, 2, 0);
      step();
      check("rr_g2", mif.resp_done, 4'b0110);
      check("rr_l2", load(2), 4);
      step();
      check("rr_g3", mif.resp_done, 4'b1110);
      check("rr_l3", load(3), 5);
      step();
      check("rr_g0_again", mif.resp_done, 4'b1111);
      check("rr_l0_again", load(0), 7);
      avail = '0;
      step();
      check("rr_all_fall", mif.resp_done, 4'b0000);

      // Host write blocks port 0 for two cycles
      port_set(0, 1, 1, 0, 4, 0);
      host_we = 1'b1; host_addr = 8'd10; host_wdata = 32'hAA;
      step();
      check("hp_c1", mif.resp_done[0], 0);
      step();
      check("hp_c2", mif.resp_done[0], 0);
      host_we = 1'b0;
      step();
      check("hp_c3", mif.resp_done[0], 1);
      check("hp_load", load(0), 5);
      avail[0] = 1'b0;
      step();
      host_rd("host_rd10", 10, 32'hAA);

      // Host write and read together return the pre-write value
      host_we = 1'b1; host_re = 1'b1; host_addr = 8'd1; host_wdata = 32'h55;
      step();
      host_we = 1'b0; host_re = 1'b0;
      check("host_wr_rd_old", host_rdata, 3);
      host_rd("host_rd1_new", 1, 32'h55);

      // Out-of-range pointer on port 2
      host_wr(44, 32'h1234);
      port_set(2, 1, 1, 1, 300, 32'hDEAD);
      step();
      check("oor_done", mif.resp_done[2], 1);
      check("oor_load", load(2), 0);
      check("oor_err",  err, 1);
      avail[2] = 1'b0;
      step();
      host_rd("oor_no_write", 44, 32'h1234);
      port_set(2, 1, 1, 0, 3, 0);
      step();
      check("oor_good_load", load(2), 4);
      check("oor_err_sticky", err, 1);
      avail[2] = 1'b0;
      step();

      // Reset while port 0 sits in DONE
      port_set(0, 1, 1, 0, 0, 0);
      step();
      check("rd_pre_done", mif.resp_done[0], 1);
      check("rd_pre_load", load(0), 1);
      #1 rst_l = 1'b0;
      #1;
      check("rd_async_done", mif.resp_done, 0);
      check("rd_async_load", load(0), 0);
      check("rd_async_err",  err, 0);
      step(); step();
      rst_l = 1'b1;
      step();
      check("rd_reissue_done", mif.resp_done[0], 1);
      check("rd_reissue_load", load(0), 1);
      avail[0] = 1'b0;
      step();
      host_rd("rd_preserved", 6, 32'h42);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fpu_mem_responder.md
Name: fpu_mem_responder

Overview:
- Memory-side responder for the mem_handle request protocol that FPU job managers drive as initiators.
- Owns a single-ported word array and services NPORTS flattened initiator ports, one access per cycle, with round-robin arbitration.
- Completes each request with the done handshake and returns read data on data_load.
- A host port preloads and inspects the array (weights, inputs, biases) before and after FPU jobs.

Parameters:
- NPORTS, 4, number of initiator ports (a, b, c, d).
- DEPTH, 256, words in the backing array.
- PTR_W, 23, pointer width of mem_handle ptr.
- DATA_W, 32, word width.

Ports:
- clk  input  1  clock
- rst_l  input  1  reset; asynchronous, active-low
- req_avail  input  NPORTS  per-port request valid, held until done seen
- req_r_en  input  NPORTS  per-port read request
- req_w_en  input  NPORTS  per-port write request
- req_ptr  input  NPORTS*PTR_W  per-port word address
- req_data_store  input  NPORTS*DATA_W  per-port write data
- resp_data_load  output  NPORTS*DATA_W  per-port read data
- resp_done  output  NPORTS  per-port completion
- host_we  input  1  host write strobe
- host_re  input  1  host read strobe
- host_addr  input  $clog2(DEPTH)  host word address
- host_wdata  input  DATA_W  host write data
- host_rdata  output  DATA_W  host read data, registered
- err  output  1  sticky out-of-range flag

Behaviour:
- Reset (async, rst_l=0):
  - resp_done=0, resp_data_load=0, host_rdata=0, err=0.
  - Round-robin pointer points at port 0; all port FSMs return to IDLE.
  - Array contents are not reset.
  - Reset mid-request drops the request with no write; the initiator must re-issue after reset.
- Per-port FSM:
  - IDLE: port is pending when req_avail=1. Granted -> access performed at that clock edge; resp_done=1 and resp_data_load valid after the edge (latency 1 cycle from grant) -> DONE.
  - DONE: resp_done held 1 and resp_data_load held stable while req_avail=1. req_avail=0 -> resp_done=0 at next edge -> IDLE.
  - A new request is accepted only from IDLE, so each request executes exactly once regardless of how long avail stays high.
- Arbitration:
  - At most one array access per cycle.
  - Among pending IDLE ports, grant the first index at or after (last_grant+1) mod NPORTS.
  - The pointer updates to the granted index only when a grant occurs.
  - A pending port waits at most NPORTS-1 grant cycles.
- Host priority: host_we or host_re in a cycle blocks all port grants that cycle.
  - host_we writes host_wdata to the array.
  - host_re loads host_rdata at the edge.
  - host_we and host_re together: write occurs, host_rdata returns the pre-write value.
- Operation decode on grant:
  - w_en only: array[ptr] <= data_store; data_load unchanged.
  - r_en only: data_load <= array[ptr].
  - Both set: data_load <= old array[ptr] and the write occurs (read-before-write).
  - Neither set: no-op, done still asserted.
- Address rule:
  - ptr >= DEPTH: no array access; data_load <= 0; err <= 1 (sticky until reset); done still asserted.
  - Only the low $clog2(DEPTH) bits index the array when in range.
- Same-cycle hazard: a write granted at edge N is visible to any read granted at edge N+1 or later.
- Ports never time out; a port held in DONE with avail=1 consumes no arbitration slots.

Test Plan:
- Host preloads array[0..4] = 1,3,3,4,5. Port1 reads ptr=3 -> resp_done[1] rises 1 cycle after avail; data_load[1]=4. Drop avail -> done falls next cycle.
- Port3 writes ptr=6 data 0x42 and holds avail 5 cycles -> single write, done high all 5 cycles. Host read addr 6 -> 0x42.
- All 4 ports request reads in the same cycle from reset -> grants in order 0,1,2,3 on consecutive cycles. Port 0 re-requests immediately -> granted after port 3.
- Port 0 read with host_we active for 2 cycles -> grant delayed exactly 2 cycles; done 3 cycles after avail.
- Port 2 reads ptr=300 (DEPTH=256) -> done=1, data_load=0, err=1, array unchanged; err stays 1 across later good requests.
- rst_l low while port 0 is in DONE -> resp_done=0 immediately; after release, re-issued request completes normally; array contents preserved.
